// File: rtl/ahblite_stream_master.sv
// ahblite_stream_master
//   AHB-Lite master that writes a stream of 32-bit words to consecutive word
//   addresses starting at a programmed base, using single pipelined NONSEQ
//   writes. Handles slave wait states and the two-cycle ERROR response.
//
// Ports
//   HCLK, HRESETn          clock, asynchronous active-low reset
//   start                  one-cycle block request (ignored while busy)
//   base_addr, word_count  block parameters, captured on start
//   wdata_valid/wdata      stream input; wdata_ready acknowledges a word
//   H*                     AHB-Lite master interface (HRDATA not used)
//   busy, done, error      status; done/error are one-cycle pulses
//   checksum               sum of OKAY-written words when
//                          STREAM_MASTER_CHECKSUM_EN is defined, else 0
module ahblite_stream_master #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] word_count,
  input  logic             wdata_valid,
  input  logic [31:0]      wdata,
  output logic             wdata_ready,
  output logic [31:0]      HADDR,
  output logic [1:0]       HTRANS,
  output logic             HWRITE,
  output logic [2:0]       HSIZE,
  output logic [2:0]       HBURST,
  output logic [3:0]       HPROT,
  output logic             HMASTLOCK,
  output logic [31:0]      HWDATA,
  input  logic             HREADY,
  input  logic             HRESP,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [31:0]      checksum
);

  typedef enum logic [1:0] {StIdle, StRun, StErr1} state_e;

  localparam logic [CNT_W-1:0] CntOne = 1;

  state_e           state_q, state_d;
  logic [31:0]      base_q, base_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic             a_valid_q, a_valid_d;
  logic [31:0]      haddr_q, haddr_d;
  logic [31:0]      a_data_q, a_data_d;
  logic             d_valid_q, d_valid_d;
  logic [31:0]      hwdata_q, hwdata_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  logic accept;
  logic a_adv;
  logic d_ok;

  assign HWRITE    = 1'b1;
  assign HSIZE     = 3'b010;
  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;

  assign HADDR  = haddr_q;
  assign HTRANS = a_valid_q ? 2'b10 : 2'b00;
  assign HWDATA = hwdata_q;
  assign busy   = (state_q != StIdle);
  assign done   = done_q;
  assign error  = error_q;

  // A pending address phase may only be replaced when the bus takes it, and
  // nothing new is taken during the first ERROR cycle.
  assign wdata_ready = (state_q == StRun) && (issued_q < count_q) &&
                       (!a_valid_q || HREADY) && !(HRESP && d_valid_q);
  assign accept      = wdata_valid && wdata_ready;
  assign a_adv       = a_valid_q && HREADY;
  assign d_ok        = d_valid_q && HREADY && !HRESP;

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    count_d   = count_q;
    issued_d  = issued_q;
    a_valid_d = a_valid_q;
    haddr_d   = haddr_q;
    a_data_d  = a_data_q;
    d_valid_d = d_valid_q;
    hwdata_d  = hwdata_q;
    done_d    = 1'b0;
    error_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          base_d   = base_addr & 32'hFFFF_FFFC;
          count_d  = word_count;
          issued_d = '0;
          if (word_count != '0) state_d = StRun;
          else                  done_d  = 1'b1;
        end
      end
      StRun: begin
        if (d_valid_q && HRESP && !HREADY) begin
          // First ERROR cycle: withdraw the pipelined address phase.
          state_d   = StErr1;
          a_valid_d = 1'b0;
        end else begin
          if (a_adv) begin
            hwdata_d  = a_data_q;
            d_valid_d = 1'b1;
          end else if (d_valid_q && HREADY) begin
            d_valid_d = 1'b0;
          end
          if (accept) begin
            a_valid_d = 1'b1;
            haddr_d   = base_q + (32'(issued_q) << 2);
            a_data_d  = wdata;
            issued_d  = issued_q + CntOne;
          end else if (a_adv) begin
            a_valid_d = 1'b0;
          end
          if (d_ok && !a_valid_q && (issued_q == count_q)) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StErr1: begin
        if (HREADY) begin
          error_d   = 1'b1;
          d_valid_d = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= StIdle;
      base_q    <= '0;
      count_q   <= '0;
      issued_q  <= '0;
      a_valid_q <= 1'b0;
      haddr_q   <= '0;
      a_data_q  <= '0;
      d_valid_q <= 1'b0;
      hwdata_q  <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      count_q   <= count_d;
      issued_q  <= issued_d;
      a_valid_q <= a_valid_d;
      haddr_q   <= haddr_d;
      a_data_q  <= a_data_d;
      d_valid_q <= d_valid_d;
      hwdata_q  <= hwdata_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

`ifdef STREAM_MASTER_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (state_q == StIdle && start)   csum_d = '0;
    else if (state_q == StRun && d_ok) csum_d = csum_q + hwdata_q;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) csum_q <= '0;
    else          csum_q <= csum_d;
  end

  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_ahblite_stream_master.sv
module tb_ahblite_stream_master;
  localparam int unsigned CNT_W = 16;
  localparam int TLEN = 20;

  logic             HCLK = 1'b0;
  logic             HRESETn;
  logic             start;
  logic [31:0]      base_addr;
  logic [CNT_W-1:0] word_count;
  logic             wdata_valid;
  logic [31:0]      wdata;
  logic             wdata_ready;
  logic [31:0]      HADDR;
  logic [1:0]       HTRANS;
  logic             HWRITE;
  logic [2:0]       HSIZE;
  logic [2:0]       HBURST;
  logic [3:0]       HPROT;
  logic             HMASTLOCK;
  logic [31:0]      HWDATA;
  logic             HREADY;
  logic             HRESP;
  logic             busy;
  logic             done;
  logic             error;
  logic [31:0]      checksum;

  ahblite_stream_master #(.CNT_W(CNT_W)) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .start       (start),
    .base_addr   (base_addr),
    .word_count  (word_count),
    .wdata_valid (wdata_valid),
    .wdata       (wdata),
    .wdata_ready (wdata_ready),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HWRITE      (HWRITE),
    .HSIZE       (HSIZE),
    .HBURST      (HBURST),
    .HPROT       (HPROT),
    .HMASTLOCK   (HMASTLOCK),
    .HWDATA      (HWDATA),
    .HREADY      (HREADY),
    .HRESP       (HRESP),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .checksum    (checksum)
  );

  always #5 HCLK = ~HCLK;

  int total = 0;
  int bad   = 0;

  // Block model: stream words, expected address progression, slave behaviour.
  logic [31:0] m_words [16];
  int          m_nsrc;
  logic [31:0] m_base;
  int acc_cnt, addr_idx, gap_after, gap_len, gap_left, wait_idx, wait_len, err_idx;
  bit dp_act, dp_err;
  int dp_idx, dp_wait, dp_es;
  logic [31:0] dp_addr;
  logic [31:0] wr_addr [$];
  logic [31:0] wr_data [$];

  logic [1:0]  tr_trans [TLEN];
  logic [31:0] tr_addr  [TLEN];
  logic [31:0] tr_wd    [TLEN];
  logic        tr_done  [TLEN];
  logic        tr_err   [TLEN];
  logic        tr_busy  [TLEN];
  logic        tr_rdy   [TLEN];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    acc_cnt = 0; addr_idx = 0; gap_left = 0; dp_act = 0; dp_err = 0;
    dp_idx = 0; dp_wait = 0; dp_es = 0; dp_addr = '0;
    wr_addr.delete(); wr_data.delete();
  endtask

  // Slave + stream source. Samples the bus at the falling edge, reacts after
  // the rising edge.
  logic [1:0]  s_trans;
  logic [31:0] s_addr, s_wd;
  logic        s_rdy, s_resp, s_acc;

  initial begin
    HREADY = 1'b1; HRESP = 1'b0; wdata_valid = 1'b0; wdata = '0;
    forever begin
      @(negedge HCLK);
      s_trans = HTRANS; s_addr = HADDR; s_wd = HWDATA;
      s_rdy = HREADY; s_resp = HRESP; s_acc = wdata_valid && wdata_ready;
      @(posedge HCLK);
      if (HRESETn) begin
        if (s_acc) begin
          acc_cnt++;
          if (acc_cnt == gap_after) gap_left = gap_len;
        end
        if (dp_act && s_rdy) begin
          if (!s_resp) begin
            wr_addr.push_back(dp_addr);
            wr_data.push_back(s_wd);
          end
          dp_act = 0;
        end
        if (s_trans == 2'b10 && s_rdy) begin
          dp_act = 1; dp_addr = s_addr; dp_idx = addr_idx; addr_idx++;
          dp_wait = (dp_idx == wait_idx) ? wait_len : 0;
          dp_err = (dp_idx == err_idx); dp_es = 0;
        end
      end
      #1;
      if (dp_act && dp_err) begin
        HRESP = 1'b1;
        HREADY = (dp_es != 0);
        dp_es = 1;
      end else if (dp_act && dp_wait > 0) begin
        HRESP = 1'b0; HREADY = 1'b0; dp_wait--;
      end else begin
        HRESP = 1'b0; HREADY = 1'b1;
      end
      if (gap_left > 0) begin
        wdata_valid = 1'b0; gap_left--;
      end else if (acc_cnt < m_nsrc) begin
        wdata_valid = 1'b1; wdata = m_words[acc_cnt];
      end else begin
        wdata_valid = 1'b0;
      end
    end
  end

  // Per-cycle compare against the model.
  bit          p_valid = 0;
  logic [1:0]  p_trans;
  logic [31:0] p_addr, p_wd;
  logic        p_rdy, p_resp;

  initial begin
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        p_valid = 0;
      end else begin
        check("const_ctrl", {20'd0, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK},
              {20'd0, 1'b1, 3'b010, 3'b000, 4'b0011, 1'b0});
        if (HTRANS == 2'b10) check("haddr_seq", HADDR, m_base + 32'(addr_idx * 4));
        else                 check("htrans_idle", {30'd0, HTRANS}, 32'd0);
        if (dp_act) check("hwdata", HWDATA, m_words[dp_idx]);
        if (!HREADY || !busy) check("ready_low", {31'd0, wdata_ready}, 32'd0);
        if (done) check("busy_with_done", {31'd0, busy}, 32'd0);
        if (p_valid && !p_rdy && !p_resp) begin
          check("wait_haddr", HADDR, p_addr);
          check("wait_htrans", {30'd0, HTRANS}, {30'd0, p_trans});
          check("wait_hwdata", HWDATA, p_wd);
        end
        if (p_valid && !p_rdy && p_resp) check("err2_idle", {30'd0, HTRANS}, 32'd0);
        p_valid = 1; p_trans = HTRANS; p_addr = HADDR; p_wd = HWDATA;
        p_rdy = HREADY; p_resp = HRESP;
      end
    end
  end

  task automatic run_block(input logic [31:0] base, input int cnt, input int gap_a,
                           input int gap_l, input int wait_i, input int wait_l,
                           input int err_i, input int exp_wr, input int exp_done,
                           input int exp_err, input string tag);
    int ndone, nerr;
    logic [31:0] sum;
    @(negedge HCLK);
    #1;
    model_clear();
    gap_after = gap_a; gap_len = gap_l; wait_idx = wait_i; wait_len = wait_l;
    err_idx = err_i; m_nsrc = cnt; m_base = base & 32'hFFFF_FFFC;
    @(posedge HCLK);
    #2;
    start = 1'b1; base_addr = base; word_count = CNT_W'(cnt);
    ndone = 0; nerr = 0;
    for (int k = 0; k < TLEN; k++) begin
      @(negedge HCLK);
      tr_trans[k] = HTRANS; tr_addr[k] = HADDR; tr_wd[k] = HWDATA;
      tr_done[k] = done; tr_err[k] = error; tr_busy[k] = busy; tr_rdy[k] = wdata_ready;
      if (done) ndone++;
      if (error) nerr++;
      @(posedge HCLK);
      #2;
      if (k == 0) start = 1'b0;
    end
    check({tag, "_done_cnt"}, 32'(ndone), 32'(exp_done));
    check({tag, "_err_cnt"}, 32'(nerr), 32'(exp_err));
    check({tag, "_writes"}, 32'(wr_addr.size()), 32'(exp_wr));
    sum = '0;
    for (int i = 0; i < exp_wr; i++) begin
      sum = sum + m_words[i];
      if (i < wr_addr.size()) begin
        check({tag, "_wr_addr"}, wr_addr[i], m_base + 32'(i * 4));
        check({tag, "_wr_data"}, wr_data[i], m_words[i]);
      end
    end
`ifdef STREAM_MASTER_CHECKSUM_EN
    check({tag, "_checksum"}, checksum, sum);
`else
    check({tag, "_checksum"}, checksum, 32'd0);
`endif
  endtask

  function automatic int count_nonseq(input int from);
    int n = 0;
    for (int k = from; k < TLEN; k++) if (tr_trans[k] == 2'b10) n++;
    return n;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_htrans"}, {30'd0, HTRANS}, 32'd0);
    check({tag, "_haddr"}, HADDR, 32'd0);
    check({tag, "_hwdata"}, HWDATA, 32'd0);
    check({tag, "_status"}, {28'd0, busy, done, error, wdata_ready}, 32'd0);
    check({tag, "_checksum"}, checksum, 32'd0);
  endtask

  initial begin
    HRESETn = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
    m_nsrc = 0; m_base = '0; gap_after = -1; gap_len = 0; wait_idx = -1;
    wait_len = 0; err_idx = -1;
    model_clear();
    for (int i = 0; i < 16; i++) m_words[i] = 32'hA5A5_0000 + 32'(i * 32'h0101_0001);
    repeat (2) @(posedge HCLK);
    #1;
    check_reset("rst");
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Continuous stream, zero-wait slave.
    run_block(32'h2000_0000, 4, -1, 0, -1, 0, -1, 4, 1, 0, "t1");
    check("t1_busy1", {31'd0, tr_busy[1]}, 32'd1);
    check("t1_trans2", {30'd0, tr_trans[2]}, 32'd2);
    check("t1_addr2", tr_addr[2], 32'h2000_0000);
    check("t1_addr3", tr_addr[3], 32'h2000_0004);
    check("t1_addr4", tr_addr[4], 32'h2000_0008);
    check("t1_addr5", tr_addr[5], 32'h2000_000C);
    check("t1_wd3", tr_wd[3], 32'hA5A5_0000);
    check("t1_wd6", tr_wd[6], 32'hA8A8_0003);
    check("t1_done7", {30'd0, tr_done[7], tr_busy[7]}, 32'd2);

    // Two wait states on the second data phase.
    run_block(32'h2000_0000, 4, -1, 0, 1, 2, -1, 4, 1, 0, "t2");
    check("t2_addr4", tr_addr[4], 32'h2000_0008);
    check("t2_addr5", tr_addr[5], 32'h2000_0008);
    check("t2_wd5", tr_wd[5], 32'hA6A6_0001);
    check("t2_rdy45", {30'd0, tr_rdy[4], tr_rdy[5]}, 32'd0);

    // Three-cycle stream gap after two words.
    run_block(32'h2000_0000, 4, 2, 3, -1, 0, -1, 4, 1, 0, "t3");
    check("t3_gap", {29'd0, tr_trans[4][1], tr_trans[5][1], tr_trans[6][1]}, 32'd0);
    check("t3_trans7", {30'd0, tr_trans[7]}, 32'd2);
    check("t3_addr7", tr_addr[7], 32'h2000_0008);

    // ERROR on the second data phase of a five-word block.
    run_block(32'h2000_0000, 5, -1, 0, -1, 0, 1, 1, 0, 1, "t4");
    check("t4_trans4", {30'd0, tr_trans[4]}, 32'd2);
    check("t4_trans5", {30'd0, tr_trans[5]}, 32'd0);
    check("t4_err6", {31'd0, tr_err[6]}, 32'd1);
    check("t4_no_more", 32'(count_nonseq(5)), 32'd0);

    // Address wrap.
    run_block(32'hFFFF_FFFC, 2, -1, 0, -1, 0, -1, 2, 1, 0, "t5");
    check("t5_addr2", tr_addr[2], 32'hFFFF_FFFC);
    check("t5_addr3", tr_addr[3], 32'h0000_0000);

    // Zero-length block.
    run_block(32'h2000_0000, 0, -1, 0, -1, 0, -1, 0, 1, 0, "t6");
    check("t6_done1", {31'd0, tr_done[1]}, 32'd1);
    check("t6_nonseq", 32'(count_nonseq(0)), 32'd0);
    check("t6_busy1", {31'd0, tr_busy[1]}, 32'd0);

    // Wrapping checksum: 1 + 2 + 0xFFFF_FFFF.
    m_words[0] = 32'd1; m_words[1] = 32'd2; m_words[2] = 32'hFFFF_FFFF;
    run_block(32'h2000_0100, 3, -1, 0, -1, 0, -1, 3, 1, 0, "t7");
`ifdef STREAM_MASTER_CHECKSUM_EN
    check("t7_sum_lit", checksum, 32'h0000_0002);
`else
    check("t7_sum_lit", checksum, 32'h0000_0000);
`endif

    // Asynchronous reset mid-block.
    m_words[0] = 32'h1234_5678; m_words[1] = 32'h0000_0011;
    @(negedge HCLK);
    #1;
    model_clear();
    gap_after = -1; wait_idx = -1; err_idx = -1; m_nsrc = 4; m_base = 32'h2000_0000;
    @(posedge HCLK);
    #2;
    start = 1'b1; base_addr = 32'h2000_0000; word_count = CNT_W'(4);
    @(posedge HCLK);
    #2;
    start = 1'b0;
    repeat (4) @(negedge HCLK);
    check("t8_busy_pre", {31'd0, busy}, 32'd1);
    #2;
    HRESETn = 1'b0;
    #1;
    check_reset("t8");
    @(negedge HCLK);
    HRESETn = 1'b1;
    model_clear();
    m_nsrc = 0;
    repeat (3) @(negedge HCLK);
    check("t8_no_resume", {29'd0, busy, HTRANS}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
